// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// start/busy/done handshake; results registered and held until the next completion.
module seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t           state_r, state_s;
    logic [WIDTH-1:0] q_r, q_s;
    logic [WIDTH-1:0] dvsr_r, dvsr_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic [WIDTH-1:0] quot_s, remo_s;
    logic             dbz_s, busy_s, done_s;
    logic [WIDTH:0]   sh_s, diff_s;
    // The partial remainder always stays below the divisor, so its
    // (WIDTH+1)-th bit is never set once stored and is not kept.
    logic [WIDTH-1:0] rem_r, rem_s;

    // Next-state, datapath iteration and next output values
    always_comb begin
        sh_s    = {rem_r, q_r[WIDTH-1]};
        diff_s  = sh_s - {1'b0, dvsr_r};
        state_s = state_r;
        q_s     = q_r;
        rem_s   = rem_r;
        dvsr_s  = dvsr_r;
        cnt_s   = cnt_r;
        quot_s  = quotient;
        remo_s  = remainder;
        dbz_s   = div_by_zero;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (divisor == {WIDTH{1'b0}}) begin
                        quot_s  = {WIDTH{1'b1}};
                        remo_s  = dividend;
                        dbz_s   = 1'b1;
                        state_s = ST_DONE;
                    end else begin
                        dvsr_s  = divisor;
                        q_s     = dividend;
                        rem_s   = {WIDTH{1'b0}};
                        cnt_s   = {CW{1'b0}};
                        state_s = ST_RUN;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // MSB of the difference is the borrow: clear means the subtract fits
                if (diff_s[WIDTH] == 1'b0) begin
                    rem_s = diff_s[WIDTH-1:0];
                    q_s   = {q_r[WIDTH-2:0], 1'b1};
                end else begin
                    rem_s = sh_s[WIDTH-1:0];
                    q_s   = {q_r[WIDTH-2:0], 1'b0};
                end
                cnt_s = cnt_r + CW'(1);
                if (cnt_r == LAST_CNT) begin
                    quot_s  = q_s;
                    remo_s  = rem_s;
                    dbz_s   = 1'b0;
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        busy_s = (state_s == ST_RUN);
        done_s = (state_s == ST_DONE);
    end

    // State, working registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            q_r         <= {WIDTH{1'b0}};
            rem_r       <= {WIDTH{1'b0}};
            dvsr_r      <= {WIDTH{1'b0}};
            cnt_r       <= {CW{1'b0}};
            quotient    <= {WIDTH{1'b0}};
            remainder   <= {WIDTH{1'b0}};
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_r     <= state_s;
            q_r         <= q_s;
            rem_r       <= rem_s;
            dvsr_r      <= dvsr_s;
            cnt_r       <= cnt_s;
            quotient    <= quot_s;
            remainder   <= remo_s;
            div_by_zero <= dbz_s;
            busy        <= busy_s;
            done        <= done_s;
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH=16): handshake timing,
// edge operands, divide by zero, protocol, mid-op reset and a random invariant sweep.
module tb_seq_divider;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = 16'd0;
    logic [W-1:0] divisor = 16'd0;
    logic [W-1:0] quotient, remainder;
    logic         busy, done, div_by_zero;

    int checks = 0;
    int errors = 0;
    int overlap_cnt = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .dividend(dividend), .divisor(divisor),
        .quotient(quotient), .remainder(remainder),
        .busy(busy), .done(done), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // busy and done must never be high together
    always @(negedge clk) begin
        if (rst_n && busy && done) overlap_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // One operation; returns done-cycle results, edges from accept to done and busy cycle count.
    // poke re-pulses start with other operands during RUN and during DONE.
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit poke,
                          output logic [W-1:0] q, output logic [W-1:0] r, output logic z,
                          output int lat, output int bcnt);
        int n;
        bcnt = 0;
        @(negedge clk);
        dividend = a; divisor = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!done && n < 100) begin
            if (busy) bcnt++;
            start = poke && (n == 5);
            dividend = 16'(($urandom % 65535) + 1);
            divisor = 16'd3;
            @(negedge clk);
            n++;
        end
        lat = n;
        q = quotient; r = remainder; z = div_by_zero;
        start = poke;
        dividend = 16'd999; divisor = 16'd5;
        @(negedge clk);
        start = 1'b0;
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("no_queued_start", {31'd0, busy}, 32'd0);
    endtask

    logic [W-1:0] q, r, a, b;
    logic         z;
    int           lat, bcnt;
    int           dn[$];
    bit           seen;

    // Directed edge vectors: dividend, divisor, quotient, remainder
    logic [W-1:0] vec [0:4][0:3];

    initial begin
        vec[0] = '{16'd100,   16'd7,     16'd14,    16'd2};
        vec[1] = '{16'd65535, 16'd1,     16'd65535, 16'd0};
        vec[2] = '{16'd5,     16'd9,     16'd0,     16'd5};
        vec[3] = '{16'd0,     16'd3,     16'd0,     16'd0};
        vec[4] = '{16'd65535, 16'd65535, 16'd1,     16'd0};

        // Reset with random inputs
        start = 1'b1; dividend = 16'(($urandom % 65535) + 1); divisor = 16'd4;
        #23;
        chk("rst_q", {16'd0, quotient}, 32'd0);
        chk("rst_r", {16'd0, remainder}, 32'd0);
        chk("rst_busy_done_dbz", {29'd0, busy, done, div_by_zero}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy || done || div_by_zero || quotient != 16'd0 || remainder != 16'd0) seen = 1'b1;
        end
        chk("idle_after_reset", {31'd0, seen}, 32'd0);

        // Basic and edge operands
        for (int i = 0; i < 5; i++) begin
            do_div(vec[i][0], vec[i][1], 1'b0, q, r, z, lat, bcnt);
            chk($sformatf("q_%0d", i), {16'd0, q}, {16'd0, vec[i][2]});
            chk($sformatf("r_%0d", i), {16'd0, r}, {16'd0, vec[i][3]});
            chk($sformatf("dbz_%0d", i), {31'd0, z}, 32'd0);
            chk($sformatf("lat_%0d", i), lat, W + 1);
            chk($sformatf("busy_cycles_%0d", i), bcnt, W);
            chk($sformatf("hold_q_%0d", i), {16'd0, quotient}, {16'd0, vec[i][2]});
            chk($sformatf("hold_r_%0d", i), {16'd0, remainder}, {16'd0, vec[i][3]});
        end

        // Divide by zero then a normal op clearing the flag
        do_div(16'd1234, 16'd0, 1'b0, q, r, z, lat, bcnt);
        chk("dz_q", {16'd0, q}, 32'd65535);
        chk("dz_r", {16'd0, r}, 32'd1234);
        chk("dz_flag", {31'd0, z}, 32'd1);
        chk("dz_lat", lat, 1);
        chk("dz_busy", bcnt, 0);
        chk("dz_hold_flag", {31'd0, div_by_zero}, 32'd1);
        do_div(16'd10, 16'd3, 1'b0, q, r, z, lat, bcnt);
        chk("after_dz_q", {16'd0, q}, 32'd3);
        chk("after_dz_r", {16'd0, r}, 32'd1);
        chk("after_dz_flag", {31'd0, z}, 32'd0);

        // start re-pulsed in RUN and DONE with other operands
        do_div(16'd100, 16'd7, 1'b1, q, r, z, lat, bcnt);
        chk("poke_q", {16'd0, q}, 32'd14);
        chk("poke_r", {16'd0, r}, 32'd2);
        chk("poke_lat", lat, W + 1);

        // start held high: done pulses exactly W+2 cycles apart
        @(negedge clk);
        dividend = 16'd100; divisor = 16'd7; start = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (done) dn.push_back(k);
        end
        start = 1'b0;
        chk("held_count", dn.size(), 3);
        if (dn.size() >= 3) begin
            chk("held_gap1", dn[1] - dn[0], W + 2);
            chk("held_gap2", dn[2] - dn[1], W + 2);
        end
        repeat (25) @(negedge clk);
        chk("held_result_q", {16'd0, quotient}, 32'd14);

        // Reset in the 8th RUN cycle of 1000/10
        dividend = 16'd1000; divisor = 16'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_q", {16'd0, quotient}, 32'd0);
        chk("mid_rst_r", {16'd0, remainder}, 32'd0);
        chk("mid_rst_flags", {29'd0, busy, done, div_by_zero}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        chk("no_done_after_abort", {31'd0, seen}, 32'd0);
        do_div(16'd1000, 16'd10, 1'b0, q, r, z, lat, bcnt);
        chk("post_rst_q", {16'd0, q}, 32'd100);
        chk("post_rst_r", {16'd0, r}, 32'd0);

        // Random operands against dividend = q*d + r, r < d
        for (int i = 0; i < 1000; i++) begin
            a = 16'($urandom);
            b = 16'(($urandom % 65535) + 1);
            do_div(a, b, 1'b0, q, r, z, lat, bcnt);
            chk("rand_identity", 32'(q) * 32'(b) + 32'(r), {16'd0, a});
            chk("rand_rem_lt", {31'd0, (r < b)}, 32'd1);
        end

        chk("busy_done_overlap", overlap_cnt, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle unsigned restoring divider for the CPU datapath. It is the inverse companion to the carry-lookahead adder/subtractor: it reuses the same subtract-and-test step, repeated one quotient bit per clock. A start/busy/done handshake lets the control unit stall while a divide is in progress. Results are registered and held until the next accepted operation.

## Interface
Parameters:
- WIDTH, 16, operand/result width in bits (≥2)

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request a divide; sampled only in IDLE
- dividend  input  WIDTH  unsigned numerator; sampled with start
- divisor  input  WIDTH  unsigned denominator; sampled with start
- quotient  output  WIDTH  registered result, held until next completion
- remainder  output  WIDTH  registered result, held until next completion
- busy  output  1  high while iterating (RUN state)
- done  output  1  single-cycle completion pulse (DONE state)
- div_by_zero  output  1  registered flag for the last completed op; valid with done, held afterwards

## Operation
- States:
  - IDLE: waiting; start=1 latches operands.
  - RUN: one iteration per edge, for exactly WIDTH edges.
  - DONE: one cycle, then always IDLE.
- Reset (async, rst_n=0): state=IDLE; quotient=0, remainder=0, busy=0, done=0, div_by_zero=0; internal counter/shift registers cleared. Takes effect immediately, including mid-RUN; the aborted op produces no done.
- IDLE with start=1 and divisor≠0: latch divisor; working quotient register Q=dividend; partial remainder R=0 (WIDTH+1 bits); count=0; go to RUN.
- IDLE with start=1 and divisor=0: go directly to DONE with quotient=all ones, remainder=dividend, div_by_zero=1. No RUN cycles.
- RUN iteration (restoring):
  - S = {R[WIDTH-1:0], Q[WIDTH-1]}
  - T = S − {0,divisor}, computed in WIDTH+1 bits
  - If T has no borrow (MSB=0): R=T and Q={Q[WIDTH-2:0],1}.
  - Otherwise: R=S and Q={Q[WIDTH-2:0],0}.
  - count increments each iteration.
- Leaving RUN: after the WIDTH-th iteration (count reaches WIDTH−1 on that edge), the same edge loads quotient=final Q, remainder=final R[WIDTH-1:0], div_by_zero=0, then enters DONE.
- Output holding: quotient, remainder and div_by_zero change only on entry to DONE or on reset. They keep the previous result throughout RUN.
- start is ignored in RUN and DONE; it is not queued. Operand inputs are don't-care except in the cycle where start is accepted.
- Invariant on every normal completion: dividend = quotient·divisor + remainder, with remainder < divisor.

## Timing
- Edge E0 accepts start (IDLE, divisor≠0):
  - busy=1 after E0 through edge E0+WIDTH.
  - busy=0 and done=1 after E0+WIDTH, for exactly one cycle.
  - done=0 and state IDLE after E0+WIDTH+1.
  - Latency from start to done is WIDTH cycles; results are valid in the done cycle.
- Divide by zero: done=1 in the cycle after E0; busy never asserts. Latency is 1 cycle.
- Back-to-back: the earliest next accepted start is at edge E0+WIDTH+2, i.e. in the first IDLE cycle after done. A start held high continuously is accepted every WIDTH+2 cycles.
- busy and done are never high together.
- No combinational path from inputs to outputs.

## Test plan
- Reset: rst_n=0 with random inputs → all outputs 0; release, hold start=0 for 20 cycles → outputs stay 0, state IDLE.
- Basic (WIDTH=16): dividend=100, divisor=7, one-cycle start → busy for 16 cycles, then done pulse with quotient=14, remainder=2, div_by_zero=0; outputs held afterwards.
- Edges: 65535/1 → q=65535, r=0. 5/9 → q=0, r=5. 0/3 → q=0, r=0. 65535/65535 → q=1, r=0. Each completes after exactly 16 cycles.
- Divide by zero: dividend=1234, divisor=0 → done one cycle after start, busy never high, q=65535, r=1234, div_by_zero=1. A following 10/3 clears the flag and gives q=3, r=1.
- Protocol: start re-pulsed during RUN and during DONE, with changed operands → ignored and the original result is returned. start held high → acceptances exactly 18 cycles apart.
- Reset mid-op: assert rst_n=0 at the 8th RUN cycle of 1000/10 → outputs 0 immediately and no done. After release, a new 1000/10 → q=100, r=0. Finish with 1000 random operand pairs checked against the invariant.
